ssb_combiner: RTL and testbench
===============================

Name: ssb_combiner

Overview:
- Downstream neighbour of the frequency shifter.
- Consumes the two 32-bit product streams (I·cos and Q·sin) and combines them into one real single-sideband sample: difference for the upper sideband, sum for the lower.
- Rounds and saturates the result to DAC width, converts it to offset binary, and buffers it in a small FIFO with a ready/valid handshake towards the DAC interface.
- Keeps saturation statistics for the host.

Parameters:
- OUT_W, 16: output sample width in bits, offset binary.
- SHIFT, 16: number of LSBs dropped after the combine, with round-half-up.
- FIFO_DEPTH, 8: output FIFO entries; must be a power of 2 and ≥ 4.
- CNT_W, 16: width of the saturation counter.

Ports:
- M100CLK, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- i_prod, input, 32: I·cos product, two's complement.
- q_prod, input, 32: Q·sin product, two's complement.
- in_valid, input, 1: the product pair is valid.
- in_ready, output, 1: the block can accept a pair this cycle.
- sideband_sel, input, 1: 0 selects the upper sideband (I−Q); 1 selects the lower sideband (I+Q). Sampled together with the data.
- out_data, output, OUT_W: FIFO head sample, offset binary.
- out_valid, output, 1: the FIFO is not empty.
- out_ready, input, 1: downstream accepts out_data this cycle.
- clr_stats, input, 1: synchronous clear of sat_count and sat_sticky.
- sat_count, output, CNT_W: number of saturated samples; stops at all-ones.
- sat_sticky, output, 1: set on any saturation; cleared only by reset or clr_stats.
- fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:

Reset (asynchronous; all sequential state):
- Pipeline valids v1 and v2 = 0.
- FIFO pointers and fifo_level = 0.
- sat_count = 0, sat_sticky = 0.
- out_valid = 0.
- out_data = 2^(OUT_W−1), i.e. mid-scale 16'h8000 at the defaults.
- Reset asserted mid-stream discards all in-flight and buffered samples; nothing is emitted after release until new input arrives.

Accept:
- A pair is accepted at an edge where in_valid & in_ready.
- in_ready = (fifo_level + v1 + v2) < FIFO_DEPTH. This is combinational and conservative: a read in the same cycle is ignored. As a result the FIFO never overflows and no accepted sample is ever dropped.

Stage 1 (accept edge E0):
- s1 = sign-extend to 33 bits, then compute i_prod − q_prod when sideband_sel = 0, or i_prod + q_prod when sideband_sel = 1.
- Exact result; no overflow is possible in 33 bits.
- v1 <= accept.

Stage 2 (E1):
- s2 = (s1 + 2^(SHIFT−1)) >>> SHIFT, computed in 34 bits, arithmetic shift.
- v2 <= v1.

Stage 3 (E2, FIFO write when v2 = 1):
- If s2 > 2^(OUT_W−1)−1, clamp to the maximum positive value; if s2 < −2^(OUT_W−1), clamp to the minimum negative value. Either clamp counts as a saturation event.
- Convert to offset binary by inverting the MSB, then write the word to the FIFO.

Saturation event:
- sat_sticky <= 1.
- sat_count increments unless it is all-ones.
- clr_stats has priority over an increment in the same cycle.

Latency:
- A sample accepted at E0 is visible on out_data with out_valid = 1 after E2, i.e. 3 cycles, when the FIFO was empty.
- Throughput is 1 sample per clock.

FIFO:
- First-word-fall-through: out_data is always the head entry; when empty it is mid-scale.
- A read occurs at an edge where out_valid & out_ready.
- Simultaneous write and read: fifo_level is unchanged and both operations take effect.
- A write into a full FIFO cannot occur (guaranteed by in_ready).
- A read while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- Samples are delivered strictly in acceptance order.

sideband_sel:
- Applies per sample. Toggling it between accepted samples takes effect exactly on the sample it accompanies.

Test Plan:
1. Rounding: upper sideband, i_prod = 0x00008000, q_prod = 0 → out_data 0x8001. i_prod = 0x00007FFF → 0x8000. i_prod = 0xFFFF8000 → 0x8000 (round half up to 0). No saturation in any case.
2. Sideband select: i_prod = 0x01000000, q_prod = 0x00400000. sel = 0 → 0x80C0; sel = 1 → 0x8140. Output order is preserved when sel alternates every cycle.
3. Saturation: sel = 0, i_prod = 0x7FFFFFFF, q_prod = 0x80000000 → 0xFFFF. Then sel = 1, i_prod = q_prod = 0x80000000 → 0x0000. After both, sat_count = 2 and sat_sticky = 1. clr_stats pulse → both read 0.
4. Latency and empty FIFO: a single accepted sample with out_ready = 1 → out_valid is high for exactly 1 cycle, 3 edges after acceptance. fifo_level reads 0, 1, 0.
5. Backpressure: out_ready = 0 with in_valid held high for 12 cycles → exactly 8 samples accepted; in_ready falls once fifo_level + v1 + v2 = 8. Then out_ready = 1 → all 8 samples drain in order, one per cycle, and in_ready reasserts.
6. Reset mid-stream: assert reset with the FIFO holding 5 samples and both pipeline stages valid → out_valid = 0, out_data = 0x8000, fifo_level = 0 immediately, without waiting for a clock edge. After release, no stale samples appear.

Source files
------------

// File: rtl/ssb_combiner.sv
// ============================================================================
// Module   : ssb_combiner
// Purpose  : Combines I*cos / Q*sin products into a rounded, saturated,
//            offset-binary SSB sample, buffered in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssb_combiner #(
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                            M100CLK,
  input  logic                            reset,
  input  logic [31:0]                     i_prod,
  input  logic [31:0]                     q_prod,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sideband_sel,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            clr_stats,
  output logic [CNT_W-1:0]                sat_count,
  output logic                            sat_sticky,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [33:0]        c_half = 34'(1) << (SHIFT - 1);
  localparam logic signed [33:0] c_max  = 34'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [33:0] c_min  = -c_max - 34'sd1;
  localparam logic [OUT_W-1:0]   c_mid  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LVL_W:0]     c_depth = (LVL_W+1)'(FIFO_DEPTH);

  logic                    r_v1, r_v2;
  logic [32:0]             r_s1;
  logic signed [33:0]      r_s2;
  logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [LVL_W-1:0]        r_level;
  logic [CNT_W-1:0]        r_sat_count;
  logic                    r_sat_sticky;

  logic                    w_accept;
  logic [LVL_W:0]          w_occ;
  logic [32:0]             w_a, w_b, w_s1;
  logic [33:0]             w_rnd;
  logic signed [33:0]      w_s2;
  logic                    w_hi, w_lo;
  logic [OUT_W-1:0]        w_clamped, w_word;
  logic                    w_sat_evt;
  logic                    w_wr, w_rd;

  // Conservative: pending pipeline entries reserve FIFO space, reads ignored.
  assign w_occ    = {1'b0, r_level} + (LVL_W+1)'(r_v1) + (LVL_W+1)'(r_v2);
  assign in_ready = (w_occ < c_depth);
  assign w_accept = in_valid & in_ready;

  assign w_a  = {i_prod[31], i_prod};
  assign w_b  = {q_prod[31], q_prod};
  assign w_s1 = sideband_sel ? (w_a + w_b) : (w_a - w_b);

  assign w_rnd = {r_s1[32], r_s1} + c_half;
  assign w_s2  = $signed(w_rnd) >>> SHIFT;

  assign w_hi      = (r_s2 > c_max);
  assign w_lo      = (r_s2 < c_min);
  assign w_clamped = w_hi ? c_max[OUT_W-1:0] :
                     w_lo ? c_min[OUT_W-1:0] : r_s2[OUT_W-1:0];
  assign w_word    = {~w_clamped[OUT_W-1], w_clamped[OUT_W-2:0]};
  assign w_sat_evt = r_v2 & (w_hi | w_lo);

  assign w_wr = r_v2;
  assign w_rd = out_valid & out_ready;

  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rptr] : c_mid;
  assign fifo_level = r_level;
  assign sat_count  = r_sat_count;
  assign sat_sticky = r_sat_sticky;

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      if (w_accept) r_s1 <= w_s1;
      if (r_v1)     r_s2 <= w_s2;
    end
  end

  // Storage needs no reset: out_data is masked to mid-scale while empty.
  always_ff @(posedge M100CLK) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      r_sat_count  <= '0;
      r_sat_sticky <= 1'b0;
    end else if (clr_stats) begin
      r_sat_count  <= '0;
      r_sat_sticky <= 1'b0;
    end else if (w_sat_evt) begin
      r_sat_sticky <= 1'b1;
      if (r_sat_count != '1) r_sat_count <= r_sat_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssb_combiner.sv
// ============================================================================
// Module   : tb_ssb_combiner
// Purpose  : Directed self-checking bench for ssb_combiner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssb_combiner;

  logic        M100CLK = 1'b0;
  logic        reset;
  logic [31:0] i_prod, q_prod;
  logic        in_valid, in_ready, sideband_sel;
  logic [15:0] out_data;
  logic        out_valid, out_ready, clr_stats;
  logic [15:0] sat_count;
  logic        sat_sticky;
  logic [3:0]  fifo_level;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 M100CLK = ~M100CLK;

  ssb_combiner dut (
    .M100CLK     (M100CLK),
    .reset       (reset),
    .i_prod      (i_prod),
    .q_prod      (q_prod),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sideband_sel(sideband_sel),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clr_stats   (clr_stats),
    .sat_count   (sat_count),
    .sat_sticky  (sat_sticky),
    .fifo_level  (fifo_level)
  );

  task automatic step();
    @(posedge M100CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] q, input logic sel);
    i_prod = i; q_prod = q; sideband_sel = sel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 0; out_ready = 0; clr_stats = 0;
    i_prod = 0; q_prod = 0; sideband_sel = 0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h8000 || fifo_level !== 4'd0 ||
        sat_count !== 16'd0 || sat_sticky !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b data=%h lvl=%0d cnt=%0d sticky=%b rdy=%b, required 0 8000 0 0 0 1",
               out_valid, out_data, fifo_level, sat_count, sat_sticky, in_ready);
    end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_rounding();
    logic [15:0] exp [3] = '{16'h8001, 16'h8000, 16'h8000};
    push(32'h0000_8000, 32'h0, 1'b0);
    push(32'h0000_7FFF, 32'h0, 1'b0);
    push(32'hFFFF_8000, 32'h0, 1'b0);
    step(); step(); step();
    tests_run++;
    if (sat_count !== 16'd0 || sat_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL rounding_nosat: cnt=%0d sticky=%b, required 0 0", sat_count, sat_sticky);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        tests_failed++;
        $display("FAIL rounding[%0d]: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp[k]);
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

  task automatic test_sideband();
    logic [15:0] exp [6] = '{16'h80C0, 16'h8140, 16'h80C0, 16'h8140, 16'h8140, 16'h80C0};
    logic        sel [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) push(32'h0100_0000, 32'h0040_0000, sel[k]);
    step(); step(); step();
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        tests_failed++;
        $display("FAIL sideband[%0d]: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp[k]);
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

  task automatic test_saturation();
    push(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    push(32'h8000_0000, 32'h8000_0000, 1'b1);
    step(); step(); step();
    tests_run++;
    if (sat_count !== 16'd2 || sat_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_stats: cnt=%0d sticky=%b, required 2 1", sat_count, sat_sticky);
    end
    tests_run++;
    if (out_data !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_pos: data=%h, required ffff", out_data);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    tests_run++;
    if (out_data !== 16'h0000 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_neg: valid=%b data=%h, required 1 0000", out_valid, out_data);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    tests_run++;
    if (sat_count !== 16'd0 || sat_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clear: cnt=%0d sticky=%b, required 0 0", sat_count, sat_sticky);
    end
  endtask

  task automatic test_latency();
    logic       vseen [4];
    logic [3:0] lvl [4];
    out_ready = 1'b1;
    push(32'h0005_0000, 32'h0, 1'b0);           // accept edge E0
    for (int k = 0; k < 4; k++) begin            // after E1..E4
      step();
      vseen[k] = out_valid;
      lvl[k]   = fifo_level;
    end
    tests_run++;
    if (vseen[0] !== 1'b0 || vseen[1] !== 1'b1 || vseen[2] !== 1'b0 || vseen[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_valid: seen %b%b%b%b after E1..E4, required 0100",
               vseen[0], vseen[1], vseen[2], vseen[3]);
    end
    tests_run++;
    if (lvl[0] !== 4'd0 || lvl[1] !== 4'd1 || lvl[2] !== 4'd0) begin
      tests_failed++;
      $display("FAIL latency_level: %0d,%0d,%0d, required 0,1,0", lvl[0], lvl[1], lvl[2]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_prod = (acc + 1) << 16; q_prod = 0; sideband_sel = 0; in_valid = 1'b1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    tests_run++;
    if (acc != 8 || fifo_level !== 4'd8 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_fill: accepted=%0d lvl=%0d rdy=%b, required 8 8 0",
               acc, fifo_level, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'h8000 + 16'(k + 1)) begin
        tests_failed++;
        $display("FAIL backpressure_drain[%0d]: valid=%b data=%h, required 1 %h",
                 k, out_valid, out_data, 16'h8000 + 16'(k + 1));
      end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_empty: valid=%b lvl=%0d rdy=%b, required 0 0 1",
               out_valid, fifo_level, in_ready);
    end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    out_ready = 1'b0;
    i_prod = 32'h0003_0000; q_prod = 0; sideband_sel = 0; in_valid = 1'b1;
    for (int k = 0; k < 7; k++) step();
    in_valid = 1'b0;
    tests_run++;
    if (fifo_level !== 4'd5 || dut.r_v1 !== 1'b1 || dut.r_v2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_setup: lvl=%0d v1=%b v2=%b, required 5 1 1",
               fifo_level, dut.r_v1, dut.r_v2);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h8000 || fifo_level !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: valid=%b data=%h lvl=%0d, required 0 8000 0",
               out_valid, out_data, fifo_level);
    end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || fifo_level !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_stale: valid_seen=%b lvl=%0d, required 0 0", seen, fifo_level);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_sideband();
    test_saturation();
    test_latency();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
